// File: rtl/tcdm_cache_rsp_reorder_pkg.sv
// Shared cluster TCDM types used by the per-core response reorder buffer.
// The user struct carries the originating core index and the reorder slot id.
package tcdm_cache_rsp_reorder_pkg;

    localparam int unsigned UserCoreIdWidth = 5;
    // Sized for the largest supported reorder depth (8 slots).
    localparam int unsigned UserRobIdWidth  = 3;
    localparam int unsigned AddrWidth       = 32;
    localparam int unsigned DataWidth       = 32;

    typedef struct packed {
        logic [UserCoreIdWidth-1:0] core_id;
        logic [UserRobIdWidth-1:0]  rob_id;
    } cluster_tcdm_user_t;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   write;
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        cluster_tcdm_user_t     user;
    } cluster_tcdm_req_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        cluster_tcdm_user_t   user;
    } cluster_tcdm_rsp_chan_t;

    typedef struct packed {
        cluster_tcdm_req_chan_t q;
        logic                   q_valid;
    } cluster_tcdm_req_t;

    typedef struct packed {
        cluster_tcdm_rsp_chan_t p;
        logic                   p_valid;
        logic                   q_ready;
    } cluster_tcdm_rsp_t;

endpackage

// File: rtl/tcdm_cache_rsp_reorder.sv
// Per-core reorder buffer: tags outgoing TCDM requests with a slot id and
// returns the out-of-order interconnect responses to the core in issue order.
module tcdm_cache_rsp_reorder
    import tcdm_cache_rsp_reorder_pkg::*;
#(
    parameter int unsigned NumOutstanding = 8,
    parameter int unsigned CoreIdWidth    = 5,
    parameter type tcdm_req_t      = cluster_tcdm_req_t,
    parameter type tcdm_rsp_t      = cluster_tcdm_rsp_t,
    parameter type tcdm_req_chan_t = cluster_tcdm_req_chan_t,
    parameter type tcdm_rsp_chan_t = cluster_tcdm_rsp_chan_t,
    parameter bit  DropCheck       = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [CoreIdWidth-1:0] core_id_i,
    input  tcdm_req_t              core_req_i,
    output tcdm_rsp_t              core_rsp_o,
    input  logic                   core_rsp_ready_i,
    output tcdm_req_t              mem_req_o,
    input  tcdm_rsp_t              mem_rsp_i,
    output logic                   mem_rsp_ready_o
);

    localparam int unsigned IdxW = $clog2(NumOutstanding);
    localparam int unsigned CntW = IdxW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(NumOutstanding);

    logic [IdxW-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]           count_q, count_d;
    logic [NumOutstanding-1:0] alloc_q, alloc_d, done_q, done_d;
    tcdm_rsp_chan_t            slot_q [NumOutstanding];
    tcdm_rsp_chan_t            slot_d [NumOutstanding];

    logic            full, req_fire, ret_fire, rsp_ok, rsp_drop;
    logic [IdxW-1:0] rsp_idx;
    tcdm_req_chan_t  req_chan;

    assign full            = (count_q == CntFull);
    assign rsp_idx         = mem_rsp_i.p.user.rob_id[IdxW-1:0];
    assign req_fire        = mem_req_o.q_valid & mem_rsp_i.q_ready;
    assign ret_fire        = done_q[head_q] & core_rsp_ready_i;
    assign rsp_ok          = mem_rsp_i.p_valid & alloc_q[rsp_idx] & ~done_q[rsp_idx];
    assign rsp_drop        = mem_rsp_i.p_valid & ~rsp_ok;
    // Every in-flight request already owns a slot, so responses never stall.
    assign mem_rsp_ready_o = 1'b1;

    always_comb begin
        req_chan              = core_req_i.q;
        req_chan.user.core_id = UserCoreIdWidth'(core_id_i);
        req_chan.user.rob_id  = UserRobIdWidth'(tail_q);

        mem_req_o         = '0;
        mem_req_o.q       = req_chan;
        mem_req_o.q_valid = core_req_i.q_valid & ~full;

        core_rsp_o         = '0;
        core_rsp_o.q_ready = mem_rsp_i.q_ready & ~full;
        core_rsp_o.p       = slot_q[head_q];
        core_rsp_o.p_valid = done_q[head_q];
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        alloc_d = alloc_q;
        done_d  = done_q;
        slot_d  = slot_q;

        if (ret_fire) begin
            head_d          = head_q + IdxW'(1);
            alloc_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (req_fire) begin
            tail_d          = tail_q + IdxW'(1);
            alloc_d[tail_q] = 1'b1;
        end
        if (rsp_ok) begin
            done_d[rsp_idx] = 1'b1;
            slot_d[rsp_idx] = mem_rsp_i.p;
        end

        if (req_fire && !ret_fire) begin
            count_d = count_q + CntW'(1);
        end else if (!req_fire && ret_fire) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
        end
    end

    // Payload storage is qualified by done_q, so it carries no reset.
    always_ff @(posedge clk_i) begin
        slot_q <= slot_d;
    end

    if (DropCheck) begin : g_drop_check
        always @(posedge clk_i) begin
            if (rst_ni) begin
                assert (!rsp_drop)
                else $warning("tcdm_cache_rsp_reorder: dropped response to rob_id %0d", rsp_idx);
            end
        end
    end

endmodule

// File: tb/tb_tcdm_cache_rsp_reorder.sv
// Bench for tcdm_cache_rsp_reorder with 4 slots; reference model is an
// issue-ordered queue of expected responses.
module tb_tcdm_cache_rsp_reorder;
    import tcdm_cache_rsp_reorder_pkg::*;

    localparam int N = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [4:0]        core_id_i;
    cluster_tcdm_req_t core_req_i, mem_req_o;
    cluster_tcdm_rsp_t core_rsp_o, mem_rsp_i;
    logic              core_rsp_ready_i, mem_rsp_ready_o;

    typedef struct {
        logic [31:0] data;
        int          rob;
        bit          avail;
    } ent_t;

    ent_t exp_q[$];
    int   next_rob = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    tcdm_cache_rsp_reorder #(
        .NumOutstanding(N),
        .CoreIdWidth   (5),
        .DropCheck     (1'b0)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .core_id_i       (core_id_i),
        .core_req_i      (core_req_i),
        .core_rsp_o      (core_rsp_o),
        .core_rsp_ready_i(core_rsp_ready_i),
        .mem_req_o       (mem_req_o),
        .mem_rsp_i       (mem_rsp_i),
        .mem_rsp_ready_o (mem_rsp_ready_o)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic bit exp_pvalid();
        return exp_q.size() > 0 && exp_q[0].avail;
    endfunction

    function automatic bit exp_qready(input bit mqr);
        return mqr && exp_q.size() < N;
    endfunction

    function automatic int pick_rsp();
        int cand[$];
        foreach (exp_q[k]) if (!exp_q[k].avail) cand.push_back(k);
        if (cand.size() == 0) return -1;
        return cand[$urandom_range(cand.size() - 1)];
    endfunction

    function automatic int find_rob(input int rob);
        foreach (exp_q[k]) if (exp_q[k].rob == rob && !exp_q[k].avail) return k;
        return -1;
    endfunction

    task automatic drive(input bit qv, input logic [31:0] addr, input bit mqr,
                         input bit crdy, input int rsp_k);
        core_req_i            = '0;
        core_req_i.q_valid    = qv;
        core_req_i.q.addr     = addr;
        core_req_i.q.strb     = 4'hF;
        core_req_i.q.user     = '1;
        mem_rsp_i             = '0;
        mem_rsp_i.q_ready     = mqr;
        if (rsp_k >= 0) begin
            mem_rsp_i.p_valid        = 1'b1;
            mem_rsp_i.p.data         = exp_q[rsp_k].data;
            mem_rsp_i.p.user.rob_id  = 3'(exp_q[rsp_k].rob);
        end
        core_rsp_ready_i = crdy;
    endtask

    // Advance the reference model across one clock edge.
    task automatic model_step(input bit qv, input logic [31:0] addr, input bit mqr,
                              input bit crdy, input int rsp_k);
        bit pv, qr;
        pv = exp_pvalid();
        qr = exp_qready(mqr);
        if (rsp_k >= 0) exp_q[rsp_k].avail = 1'b1;
        if (pv && crdy) void'(exp_q.pop_front());
        if (qv && qr) begin
            exp_q.push_back('{mem_data(addr), next_rob, 1'b0});
            next_rob = (next_rob + 1) % N;
        end
    endtask

    task automatic settle();
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            int k;
            k = pick_rsp();
            @(negedge clk_i);
            drive(1'b0, 32'h0, 1'b1, 1'b1, k);
            model_step(1'b0, 32'h0, 1'b1, 1'b1, k);
        end
    endtask

    task automatic test_reset();
        rst_ni    = 1'b0;
        core_id_i = 5'd3;
        drive(1'b0, 32'h0, 1'b1, 1'b0, -1);
        repeat (2) @(negedge clk_i);
        #1;
        n_checks += 3;
        if (core_rsp_o.p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p_valid: got %b want 0", core_rsp_o.p_valid); end
        if (mem_req_o.q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_q_valid: got %b want 0", mem_req_o.q_valid); end
        if (mem_rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_mem_rsp_ready: got %b want 1", mem_rsp_ready_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk_i);
            drive(1'b0, 32'h0, 1'(v), 1'b0, -1);
            #1;
            n_checks++;
            if (core_rsp_o.q_ready !== 1'(v)) begin n_fail++; $display("FAIL reset_q_ready: got %b want %0d", core_rsp_o.q_ready, v); end
        end
        exp_q.delete();
        next_rob = 0;
    endtask

    task automatic test_reorder();
        int          ord [4] = '{2, 0, 3, 1};
        logic [31:0] addr[4] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_2008, 32'h0000_300C};
        int          got = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            drive(1'b1, addr[i], 1'b1, 1'b0, -1);
            #1;
            n_checks += 2;
            if (mem_req_o.q_valid !== 1'b1) begin n_fail++; $display("FAIL reorder_q_valid: got %b want 1", mem_req_o.q_valid); end
            if (mem_req_o.q.user.rob_id !== 3'(next_rob) || mem_req_o.q.addr !== addr[i])
                begin n_fail++; $display("FAIL reorder_req: got rob %0d addr %h want rob %0d addr %h",
                      mem_req_o.q.user.rob_id, mem_req_o.q.addr, next_rob, addr[i]); end
            model_step(1'b1, addr[i], 1'b1, 1'b0, -1);
        end
        for (int j = 0; j < 10; j++) begin
            int k;
            k = (j < 4) ? find_rob(ord[j]) : -1;
            @(negedge clk_i);
            drive(1'b0, 32'h0, 1'b1, 1'b1, k);
            #1;
            n_checks++;
            if (core_rsp_o.p_valid !== exp_pvalid()) begin n_fail++; $display("FAIL reorder_p_valid: cycle %0d got %b want %b", j, core_rsp_o.p_valid, exp_pvalid()); end
            if (exp_pvalid()) begin
                n_checks++;
                if (core_rsp_o.p.data !== exp_q[0].data) begin n_fail++; $display("FAIL reorder_p_data: got %h want %h", core_rsp_o.p.data, exp_q[0].data); end
            end
            if (core_rsp_o.p_valid === 1'b1) got++;
            model_step(1'b0, 32'h0, 1'b1, 1'b1, k);
        end
        n_checks++;
        if (got != 4) begin n_fail++; $display("FAIL reorder_count: got %0d responses want 4", got); end
    endtask

    task automatic test_full();
        int          hs = 0;
        logic [31:0] a;
        settle();
        for (int c = 0; c < 7; c++) begin
            a = 32'h4000 + 32'($urandom_range(255)) * 4;
            @(negedge clk_i);
            drive(1'b1, a, 1'b1, 1'b0, -1);
            #1;
            n_checks += 2;
            if (core_rsp_o.q_ready !== exp_qready(1'b1)) begin n_fail++; $display("FAIL full_q_ready: cycle %0d got %b want %b", c, core_rsp_o.q_ready, exp_qready(1'b1)); end
            if (mem_req_o.q_valid !== exp_qready(1'b1)) begin n_fail++; $display("FAIL full_mem_q_valid: cycle %0d got %b want %b", c, mem_req_o.q_valid, exp_qready(1'b1)); end
            if (core_rsp_o.q_ready === 1'b1) hs++;
            model_step(1'b1, a, 1'b1, 1'b0, -1);
        end
        n_checks++;
        if (hs != N) begin n_fail++; $display("FAIL full_handshakes: got %0d want %0d", hs, N); end
        @(negedge clk_i);
        drive(1'b1, a, 1'b1, 1'b0, 0);
        model_step(1'b1, a, 1'b1, 1'b0, 0);
        @(negedge clk_i);
        drive(1'b1, a, 1'b1, 1'b1, -1);
        #1;
        n_checks += 2;
        if (core_rsp_o.p_valid !== 1'b1) begin n_fail++; $display("FAIL full_head_valid: got %b want 1", core_rsp_o.p_valid); end
        if (core_rsp_o.q_ready !== exp_qready(1'b1)) begin n_fail++; $display("FAIL full_retire_q_ready: got %b want %b", core_rsp_o.q_ready, exp_qready(1'b1)); end
        model_step(1'b1, a, 1'b1, 1'b1, -1);
        @(negedge clk_i);
        drive(1'b1, a, 1'b1, 1'b0, -1);
        #1;
        n_checks += 2;
        if (core_rsp_o.q_ready !== exp_qready(1'b1)) begin n_fail++; $display("FAIL full_after_q_ready: got %b want %b", core_rsp_o.q_ready, exp_qready(1'b1)); end
        if (mem_req_o.q.user.rob_id !== 3'(next_rob)) begin n_fail++; $display("FAIL full_after_rob: got %0d want %0d", mem_req_o.q.user.rob_id, next_rob); end
        model_step(1'b1, a, 1'b1, 1'b0, -1);
    endtask

    task automatic test_stall();
        logic [31:0] a;
        settle();
        for (int i = 0; i < 3; i++) begin
            a = 32'h5000 + 32'(i) * 4;
            @(negedge clk_i);
            drive(1'b1, a, 1'b1, 1'b0, -1);
            model_step(1'b1, a, 1'b1, 1'b0, -1);
        end
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 0);
        model_step(1'b0, 32'h0, 1'b1, 1'b0, 0);
        for (int c = 0; c < 10; c++) begin
            int k;
            bit qv;
            k  = pick_rsp();
            qv = (c == 2);
            a  = 32'h5100;
            @(negedge clk_i);
            drive(qv, a, 1'b1, 1'b0, k);
            #1;
            n_checks += 3;
            if (core_rsp_o.p_valid !== 1'b1) begin n_fail++; $display("FAIL stall_p_valid: cycle %0d got %b want 1", c, core_rsp_o.p_valid); end
            if (core_rsp_o.p.data !== exp_q[0].data) begin n_fail++; $display("FAIL stall_p_data: cycle %0d got %h want %h", c, core_rsp_o.p.data, exp_q[0].data); end
            if (mem_rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_mem_rsp_ready: got %b want 1", mem_rsp_ready_o); end
            model_step(qv, a, 1'b1, 1'b0, k);
        end
    endtask

    task automatic test_ids();
        logic [31:0] a;
        settle();
        core_id_i = 5'd7;
        for (int c = 0; c < 12; c++) begin
            int k;
            k = pick_rsp();
            a = 32'h6000 + 32'(c) * 4;
            @(negedge clk_i);
            drive(1'b1, a, 1'b1, 1'b1, k);
            #1;
            if (exp_qready(1'b1)) begin
                n_checks++;
                if (mem_req_o.q.user.rob_id !== 3'(next_rob) || mem_req_o.q.user.core_id !== 5'd7)
                    begin n_fail++; $display("FAIL ids_user: got core %0d rob %0d want core 7 rob %0d",
                          mem_req_o.q.user.core_id, mem_req_o.q.user.rob_id, next_rob); end
            end
            model_step(1'b1, a, 1'b1, 1'b1, k);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit          qv, mqr, crdy;
            int          k;
            logic [31:0] a;
            logic [4:0]  cid;
            qv   = ($urandom_range(9) < 7);
            mqr  = ($urandom_range(9) < 8);
            crdy = ($urandom_range(9) < 6);
            k    = ($urandom_range(9) < 6) ? pick_rsp() : -1;
            a    = $urandom;
            cid  = 5'($urandom);
            @(negedge clk_i);
            core_id_i = cid;
            drive(qv, a, mqr, crdy, k);
            #1;
            n_checks += 3;
            if (core_rsp_o.p_valid !== exp_pvalid()) begin n_fail++; $display("FAIL rand_p_valid: cycle %0d got %b want %b", c, core_rsp_o.p_valid, exp_pvalid()); end
            if (core_rsp_o.q_ready !== exp_qready(mqr)) begin n_fail++; $display("FAIL rand_q_ready: cycle %0d got %b want %b", c, core_rsp_o.q_ready, exp_qready(mqr)); end
            if (mem_req_o.q_valid !== (qv && exp_q.size() < N)) begin n_fail++; $display("FAIL rand_mem_q_valid: cycle %0d got %b", c, mem_req_o.q_valid); end
            if (exp_pvalid()) begin
                n_checks++;
                if (core_rsp_o.p.data !== exp_q[0].data) begin n_fail++; $display("FAIL rand_p_data: cycle %0d got %h want %h", c, core_rsp_o.p.data, exp_q[0].data); end
            end
            if (qv && exp_qready(mqr)) begin
                n_checks++;
                if (mem_req_o.q.user.rob_id !== 3'(next_rob) || mem_req_o.q.user.core_id !== cid || mem_req_o.q.addr !== a)
                    begin n_fail++; $display("FAIL rand_req: cycle %0d got rob %0d core %0d want rob %0d core %0d",
                          c, mem_req_o.q.user.rob_id, mem_req_o.q.user.core_id, next_rob, cid); end
            end
            model_step(qv, a, mqr, crdy, k);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        settle();
        for (int i = 0; i < 3; i++) begin
            a = 32'h7000 + 32'(i) * 4;
            @(negedge clk_i);
            drive(1'b1, a, 1'b1, 1'b0, -1);
            model_step(1'b1, a, 1'b1, 1'b0, -1);
        end
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 0);
        model_step(1'b0, 32'h0, 1'b1, 1'b0, 0);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 1'b0, -1);
        #1;
        n_checks++;
        if (core_rsp_o.p_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b want 1", core_rsp_o.p_valid); end
        rst_ni = 1'b0;
        #1;
        n_checks += 3;
        if (core_rsp_o.p_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_p_valid: got %b want 0", core_rsp_o.p_valid); end
        if (dut.count_q !== '0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", dut.count_q); end
        if (core_rsp_o.q_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_q_ready: got %b want 1", core_rsp_o.q_ready); end
        exp_q.delete();
        next_rob = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 1'b0, -1);
        mem_rsp_i.p_valid       = 1'b1;
        mem_rsp_i.p.user.rob_id = 3'd1;
        mem_rsp_i.p.data        = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (dut.rsp_drop !== 1'b1) begin n_fail++; $display("FAIL late_rsp_drop: got %b want 1", dut.rsp_drop); end
        for (int i = 0; i < 2; i++) begin
            a = 32'h7100 + 32'(i) * 4;
            @(negedge clk_i);
            drive(1'b1, a, 1'b1, 1'b0, -1);
            #1;
            n_checks++;
            if (core_rsp_o.p_valid !== 1'b0) begin n_fail++; $display("FAIL late_p_valid: got %b want 0", core_rsp_o.p_valid); end
            model_step(1'b1, a, 1'b1, 1'b0, -1);
        end
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 0);
        model_step(1'b0, 32'h0, 1'b1, 1'b0, 0);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 1'b0, -1);
        mem_rsp_i.p_valid       = 1'b1;
        mem_rsp_i.p.user.rob_id = 3'd0;
        mem_rsp_i.p.data        = 32'h0BAD_0BAD;
        #1;
        n_checks++;
        if (dut.rsp_drop !== 1'b1) begin n_fail++; $display("FAIL done_rsp_drop: got %b want 1", dut.rsp_drop); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            drive(1'b0, 32'h0, 1'b1, 1'b1, -1);
            #1;
            n_checks++;
            if (core_rsp_o.p_valid !== exp_pvalid()) begin n_fail++; $display("FAIL rstmid_head: cycle %0d got %b want %b", c, core_rsp_o.p_valid, exp_pvalid()); end
            if (exp_pvalid()) begin
                n_checks++;
                if (core_rsp_o.p.data !== exp_q[0].data) begin n_fail++; $display("FAIL rstmid_data: got %h want %h", core_rsp_o.p.data, exp_q[0].data); end
            end
            model_step(1'b0, 32'h0, 1'b1, 1'b1, -1);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_reorder();
        test_full();
        test_stall();
        test_ids();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
